// File: rtl/startup_sequencer.sv
// Power-on startup sequencer: waits out power-on, enables the clock gate, then
// releases per-channel resets one at a time as each channel reports ready.
module startup_sequencer #(
    parameter int N_CH           = 2,
    parameter int POR_CYCLES     = 18750,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] ch_ready,
    output logic            clk_en,
    output logic [N_CH-1:0] rst_out,
    output logic            done,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [2:0]      phase
);

    localparam logic [2:0] POR_WAIT = 3'd0;
    localparam logic [2:0] SETTLE   = 3'd1;
    localparam logic [2:0] RELEASE  = 3'd2;
    localparam logic [2:0] GAP      = 3'd3;
    localparam logic [2:0] RUN      = 3'd4;
    localparam logic [2:0] FAULT    = 3'd5;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_TIMEOUT = 2'd1;
    localparam logic [1:0] CODE_LOST    = 2'd2;

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    localparam logic [CNT_W-1:0] POR_C     = CNT_W'(POR_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] edge_cnt, edge_n;
    logic [CNT_W-1:0] wait_cnt, wait_n, wait_inc;
    logic [IDX_W-1:0] idx, idx_n;
    logic             clk_en_n;
    logic [N_CH-1:0]  rst_out_n;
    logic             done_n;
    logic             fault_n;
    logic [1:0]       code_n;

    assign phase = state;

    always_comb begin
        // Edge counter saturates so a very long run can never wrap into a false timeout.
        edge_n    = (edge_cnt == {CNT_W{1'b1}}) ? edge_cnt : edge_cnt + 1'b1;
        wait_inc  = wait_cnt + 1'b1;
        state_n   = state;
        wait_n    = wait_cnt;
        idx_n     = idx;
        clk_en_n  = clk_en;
        rst_out_n = rst_out;
        done_n    = done;
        fault_n   = fault;
        code_n    = fault_code;

        case (state)
            POR_WAIT: begin
                if (edge_n >= POR_C) begin
                    state_n  = SETTLE;
                    clk_en_n = 1'b1;
                    wait_n   = '0;
                end
            end
            SETTLE: begin
                if (wait_inc >= SETTLE_C) begin
                    state_n      = RELEASE;
                    idx_n        = '0;
                    rst_out_n[0] = 1'b0;
                    wait_n       = '0;
                end else begin
                    wait_n = wait_inc;
                end
            end
            RELEASE: begin
                if (ch_ready[idx]) begin
                    wait_n = '0;
                    if (idx == LAST_IDX) begin
                        state_n = RUN;
                        done_n  = 1'b1;
                    end else begin
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (wait_inc >= SETTLE_C) begin
                    state_n          = RELEASE;
                    idx_n            = idx + 1'b1;
                    rst_out_n[idx_n] = 1'b0;
                    wait_n           = '0;
                end else begin
                    wait_n = wait_inc;
                end
            end
            RUN: begin
                if (ch_ready != {N_CH{1'b1}}) begin
                    state_n   = FAULT;
                    fault_n   = 1'b1;
                    code_n    = CODE_LOST;
                    done_n    = 1'b0;
                    clk_en_n  = 1'b1;
                    rst_out_n = '1;
                end
            end
            FAULT: begin
                state_n = FAULT;
            end
            default: begin
                state_n = POR_WAIT;
            end
        endcase

        // Evaluated last so a timeout overrides a RUN entry on the same edge.
        if (TIMEOUT_CYCLES > 0 && state != RUN && state != FAULT && edge_n >= TIMEOUT_C) begin
            state_n   = FAULT;
            fault_n   = 1'b1;
            code_n    = CODE_TIMEOUT;
            done_n    = 1'b0;
            clk_en_n  = 1'b1;
            rst_out_n = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= POR_WAIT;
            edge_cnt   <= '0;
            wait_cnt   <= '0;
            idx        <= '0;
            clk_en     <= 1'b0;
            rst_out    <= '1;
            done       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
        end else begin
            state      <= state_n;
            edge_cnt   <= edge_n;
            wait_cnt   <= wait_n;
            idx        <= idx_n;
            clk_en     <= clk_en_n;
            rst_out    <= rst_out_n;
            done       <= done_n;
            fault      <= fault_n;
            fault_code <= code_n;
        end
    end

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench for startup_sequencer: nominal bring-up, timeout, ready loss,
// mid-sequence reset, zero power-on wait and timeout/RUN collision.
module tb_startup_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: main configuration
    logic       rst_a = 1'b1;
    logic [1:0] ready_a = 2'b00;
    logic       clk_en_a, done_a, fault_a;
    logic [1:0] rst_out_a, code_a;
    logic [2:0] phase_a;

    // dut_b: zero power-on wait, timeout disabled
    logic       rst_b = 1'b1;
    logic [1:0] ready_b = 2'b00;
    logic       clk_en_b, done_b, fault_b;
    logic [1:0] rst_out_b, code_b;
    logic [2:0] phase_b;

    // dut_c: timeout lands on the same edge as RUN entry
    logic       rst_c = 1'b1;
    logic [1:0] ready_c = 2'b00;
    logic       clk_en_c, done_c, fault_c;
    logic [1:0] rst_out_c, code_c;
    logic [2:0] phase_c;

    int tests_run = 0;
    int tests_failed = 0;
    int ecount = 0;

    startup_sequencer #(.N_CH(2), .POR_CYCLES(10), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .ch_ready(ready_a), .clk_en(clk_en_a), .rst_out(rst_out_a),
        .done(done_a), .fault(fault_a), .fault_code(code_a), .phase(phase_a));

    startup_sequencer #(.N_CH(2), .POR_CYCLES(0), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst_b), .ch_ready(ready_b), .clk_en(clk_en_b), .rst_out(rst_out_b),
        .done(done_b), .fault(fault_b), .fault_code(code_b), .phase(phase_b));

    startup_sequencer #(.N_CH(2), .POR_CYCLES(10), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(20), .CNT_W(32)) dut_c (
        .clk(clk), .rst(rst_c), .ch_ready(ready_c), .clk_en(clk_en_c), .rst_out(rst_out_c),
        .done(done_c), .fault(fault_c), .fault_code(code_c), .phase(phase_c));

    task automatic tick_to(input int k);
        while (ecount < k) begin
            @(posedge clk);
            #1;
            ecount++;
        end
    endtask

    task automatic release_a();
        @(negedge clk);
        rst_a = 1'b0;
        ecount = 0;
    endtask

    task automatic run_nominal_a(input string tag);
        logic       e_clk_en, e_done;
        logic [1:0] e_rst;
        logic [2:0] e_phase;
        for (int e = 1; e <= 20; e++) begin
            tick_to(e);
            e_clk_en = (e >= 10);
            e_done   = (e >= 20);
            e_rst    = {e < 19, e < 14};
            e_phase  = (e < 10) ? 3'd0 : (e < 14) ? 3'd1 : (e == 14) ? 3'd2 :
                       (e < 19) ? 3'd3 : (e == 19) ? 3'd2 : 3'd4;
            tests_run++;
            if ({clk_en_a, rst_out_a, done_a, fault_a, phase_a} !== {e_clk_en, e_rst, e_done, 1'b0, e_phase}) begin
                tests_failed++;
                $display("FAIL %s edge %0d: clk_en=%b rst_out=%b done=%b fault=%b phase=%0d, required clk_en=%b rst_out=%b done=%b fault=0 phase=%0d",
                         tag, e, clk_en_a, rst_out_a, done_a, fault_a, phase_a, e_clk_en, e_rst, e_done, e_phase);
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        ready_a = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({clk_en_a, rst_out_a, done_a, fault_a, code_a, phase_a} !== {1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got clk_en=%b rst_out=%b done=%b fault=%b code=%0d phase=%0d, required 0 11 0 0 0 0",
                     clk_en_a, rst_out_a, done_a, fault_a, code_a, phase_a);
        end
    endtask

    task automatic test_nominal();
        rst_a = 1'b1;
        ready_a = 2'b11;
        #1;
        release_a();
        run_nominal_a("nominal");
    endtask

    task automatic test_ready_lost();
        int bad;
        rst_a = 1'b1;
        ready_a = 2'b11;
        #1;
        release_a();
        run_nominal_a("lost_pre");
        tick_to(50);
        tests_run++;
        if (done_a !== 1'b1 || phase_a !== 3'd4) begin
            tests_failed++;
            $display("FAIL lost_run_e50: done=%b phase=%0d, required done=1 phase=4", done_a, phase_a);
        end
        ready_a = 2'b01;
        tick_to(51);
        tests_run++;
        if ({fault_a, code_a, done_a, rst_out_a, clk_en_a, phase_a} !== {1'b1, 2'd2, 1'b0, 2'b11, 1'b1, 3'd5}) begin
            tests_failed++;
            $display("FAIL lost_fault_e51: fault=%b code=%0d done=%b rst_out=%b clk_en=%b phase=%0d, required 1 2 0 11 1 5",
                     fault_a, code_a, done_a, rst_out_a, clk_en_a, phase_a);
        end
        ready_a = 2'b11;
        bad = 0;
        for (int e = 52; e <= 251; e++) begin
            tick_to(e);
            if ({fault_a, code_a, done_a, rst_out_a, clk_en_a, phase_a} !== {1'b1, 2'd2, 1'b0, 2'b11, 1'b1, 3'd5})
                bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL lost_sticky: %0d edges left the fault state, required 0", bad);
        end
    endtask

    task automatic test_timeout();
        logic       e_fault;
        logic [1:0] e_rst, e_code;
        logic [2:0] e_phase;
        rst_a = 1'b1;
        ready_a = 2'b00;
        #1;
        release_a();
        for (int e = 1; e <= 100; e++) begin
            tick_to(e);
            if (e == 30) ready_a = 2'b01;
            e_fault = (e >= 100);
            e_code  = (e >= 100) ? 2'd1 : 2'd0;
            e_rst   = (e >= 100) ? 2'b11 : {e < 35, e < 14};
            e_phase = (e < 10) ? 3'd0 : (e < 14) ? 3'd1 : (e < 31) ? 3'd2 :
                      (e < 35) ? 3'd3 : (e < 100) ? 3'd2 : 3'd5;
            tests_run++;
            if ({clk_en_a, rst_out_a, done_a, fault_a, code_a, phase_a} !== {e >= 10, e_rst, 1'b0, e_fault, e_code, e_phase}) begin
                tests_failed++;
                $display("FAIL timeout edge %0d: clk_en=%b rst_out=%b done=%b fault=%b code=%0d phase=%0d, required rst_out=%b done=0 fault=%b code=%0d phase=%0d",
                         e, clk_en_a, rst_out_a, done_a, fault_a, code_a, phase_a, e_rst, e_fault, e_code, e_phase);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_a = 1'b1;
        ready_a = 2'b11;
        #1;
        release_a();
        tick_to(17);
        tests_run++;
        if (phase_a !== 3'd3) begin
            tests_failed++;
            $display("FAIL mid_in_gap: phase=%0d, required 3", phase_a);
        end
        rst_a = 1'b1;
        #2;
        tests_run++;
        if ({clk_en_a, rst_out_a, done_a, fault_a, code_a, phase_a} !== {1'b0, 2'b11, 1'b0, 1'b0, 2'd0, 3'd0}) begin
            tests_failed++;
            $display("FAIL mid_async_reset: clk_en=%b rst_out=%b done=%b fault=%b code=%0d phase=%0d, required 0 11 0 0 0 0",
                     clk_en_a, rst_out_a, done_a, fault_a, code_a, phase_a);
        end
        release_a();
        run_nominal_a("mid_restart");
    endtask

    task automatic test_por_zero();
        int bad;
        rst_b = 1'b1;
        ready_b = 2'b00;
        @(negedge clk);
        rst_b = 1'b0;
        ecount = 0;
        tick_to(1);
        tests_run++;
        if (clk_en_b !== 1'b1 || phase_b !== 3'd1) begin
            tests_failed++;
            $display("FAIL por0_e1: clk_en=%b phase=%0d, required 1 1", clk_en_b, phase_b);
        end
        tick_to(4);
        tests_run++;
        if (rst_out_b !== 2'b11) begin
            tests_failed++;
            $display("FAIL por0_e4: rst_out=%b, required 11", rst_out_b);
        end
        tick_to(5);
        tests_run++;
        if (rst_out_b !== 2'b10 || phase_b !== 3'd2) begin
            tests_failed++;
            $display("FAIL por0_e5: rst_out=%b phase=%0d, required 10 2", rst_out_b, phase_b);
        end
        bad = 0;
        for (int e = 6; e <= 10000; e++) begin
            tick_to(e);
            if ({fault_b, code_b, clk_en_b, rst_out_b, done_b, phase_b} !== {1'b0, 2'd0, 1'b1, 2'b10, 1'b0, 3'd2})
                bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL por0_long_wait: %0d edges deviated from RELEASE idle, required 0", bad);
        end
        ready_b = 2'b11;
        tick_to(10001);
        tests_run++;
        if (phase_b !== 3'd3) begin
            tests_failed++;
            $display("FAIL por0_gap: phase=%0d, required 3", phase_b);
        end
        tick_to(10005);
        tests_run++;
        if (rst_out_b !== 2'b00 || phase_b !== 3'd2 || done_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL por0_rel1: rst_out=%b phase=%0d done=%b, required 00 2 0", rst_out_b, phase_b, done_b);
        end
        tick_to(10006);
        tests_run++;
        if (done_b !== 1'b1 || phase_b !== 3'd4 || fault_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL por0_done: done=%b phase=%0d fault=%b, required 1 4 0", done_b, phase_b, fault_b);
        end
        rst_b = 1'b1;
    endtask

    task automatic test_timeout_vs_run();
        rst_c = 1'b1;
        ready_c = 2'b11;
        @(negedge clk);
        rst_c = 1'b0;
        ecount = 0;
        tick_to(19);
        tests_run++;
        if (rst_out_c !== 2'b00 || fault_c !== 1'b0 || done_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_run_e19: rst_out=%b fault=%b done=%b, required 00 0 0", rst_out_c, fault_c, done_c);
        end
        tick_to(20);
        tests_run++;
        if ({fault_c, code_c, done_c, rst_out_c, phase_c} !== {1'b1, 2'd1, 1'b0, 2'b11, 3'd5}) begin
            tests_failed++;
            $display("FAIL tmo_run_e20: fault=%b code=%0d done=%b rst_out=%b phase=%0d, required 1 1 0 11 5",
                     fault_c, code_c, done_c, rst_out_c, phase_c);
        end
        rst_c = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ready_lost();
        test_timeout();
        test_reset_mid();
        test_por_zero();
        test_timeout_vs_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/startup_sequencer.md
STARTUP_SEQUENCER -- requirements
Module: startup_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of reset channels, 1..8.
REQ-002 SHALL have parameter POR_CYCLES, default 18750: power-on wait, 150 us at 125 MHz, 0 permitted.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16: wait between clk_en rising and the first channel release, and between consecutive channel releases; minimum 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 0: bound on reset-exit to done; 0 disables the timeout.
REQ-005 SHALL have parameter CNT_W, default 32: width of all internal counters.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 ch_ready  input  N_CH  per-channel init-complete, e.g. HyperRAM calibrated; synchronous to clk.
REQ-009 clk_en  output  1  enable to the downstream clock gate.
REQ-010 rst_out  output  N_CH  per-channel reset, active-high.
REQ-011 done  output  1  all channels released and ready.
REQ-012 fault  output  1  sticky fault flag.
REQ-013 fault_code  output  2  0 = none, 1 = timeout, 2 = ready lost after done.
REQ-014 phase  output  3  current state: POR_WAIT=0, SETTLE=1, RELEASE=2, GAP=3, RUN=4, FAULT=5.

Function
REQ-015 SHALL count rising edges from reset deassertion; "edge k" in this spec means the k-th such edge.
REQ-016 POR_WAIT: SHALL hold clk_en=0 and rst_out all 1; SHALL enter SETTLE and set clk_en=1 at edge POR_CYCLES (edge 1 if POR_CYCLES=0).
REQ-017 SETTLE: SHALL keep all rst_out at 1 for SETTLE_CYCLES edges; SHALL then enter RELEASE with idx=0 and clear rst_out[0] on that same edge.
REQ-018 RELEASE: SHALL hold rst_out[idx]=0 and wait with no bound other than the timeout; the first edge sampling ch_ready[idx]=1 SHALL advance the state.
REQ-019 On that edge, if idx<N_CH-1, SHALL enter GAP; if idx=N_CH-1, SHALL enter RUN and set done=1.
REQ-020 GAP: after SETTLE_CYCLES edges, SHALL increment idx, clear rst_out[idx] and re-enter RELEASE.
REQ-021 Released channels SHALL stay released; channels are released strictly in ascending index order.
REQ-022 RUN: done=1; if any ch_ready bit samples 0, SHALL enter FAULT with fault_code=2.
REQ-023 Timeout: if TIMEOUT_CYCLES>0 and the edge count reaches TIMEOUT_CYCLES before RUN is entered, SHALL enter FAULT on that edge with fault_code=1.
REQ-024 If the timeout and entry into RUN fall on the same edge, the timeout SHALL win.
REQ-025 FAULT: SHALL set fault=1, done=0, clk_en=1 and all rst_out to 1; SHALL hold this until rst is asserted; fault_code SHALL not change.
REQ-026 The edge counter SHALL saturate at all-ones and SHALL not wrap; ch_ready bits above idx SHALL be ignored before RUN.
REQ-027 All outputs SHALL be registered; no combinational path from ch_ready to any output.

Reset
REQ-028 rst assertion SHALL immediately, asynchronously, and at any point mid-sequence force POR_WAIT, clk_en=0, rst_out all 1, done=0, fault=0, fault_code=0, phase=0, idx=0 and all counters 0.
REQ-029 After rst deasserts, the sequence SHALL restart from REQ-016.

Verification
Use N_CH=2, POR_CYCLES=10, SETTLE_CYCLES=4, TIMEOUT_CYCLES=100 unless noted.
REQ-030 ch_ready tied 2'b11 -> clk_en rises at edge 10, rst_out[0] falls at edge 14, rst_out[1] falls at edge 19, done rises at edge 20, fault stays 0.
REQ-031 ch_ready[0] raised at edge 30 and ch_ready[1] held 0 -> rst_out[1] falls at edge 35; fault=1, fault_code=1, rst_out=2'b11 at edge 100; done never rises.
REQ-032 Sequence of REQ-030 completes, then ch_ready[1] dropped at edge 50 -> fault_code=2, done=0, rst_out=2'b11 on the next edge; state remains sticky for 200 further edges.
REQ-033 rst pulsed during GAP at edge 17 -> outputs return to reset values with no clock edge; the REQ-030 timing repeats relative to the new deassertion.
REQ-034 POR_CYCLES=0, TIMEOUT_CYCLES=0, ch_ready held 0 for 10000 edges -> clk_en=1 from edge 1, rst_out[0]=0 from edge 5, no fault raised; asserting ch_ready then completes the sequence normally.
